// File: rtl/am_phase_seq.sv
// Four-phase T0..T3 sequencer driving a 2-to-4 decoder, with a ready-stretched T2
// phase that gives up after TIMEOUT not-ready cycles and raises a sticky flag.
module am_phase_seq #(
   parameter int TIMEOUT = 8,
   parameter int WCW     = 4
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic       start,
   input  logic       rep,
   input  logic       rdy,
   input  logic       abort,
   output logic [1:0] ph,
   output logic       ph_en,
   output logic       busy,
   output logic       done,
   output logic       tmo
);

   // Bit 2 is the decoder enable and bits 1:0 are the phase code. The state
   // register therefore drives ph/ph_en/busy directly, so the decoder sees
   // both fields change on one edge with no intermediate code.
   typedef enum logic [2:0] {
      IDLE = 3'b000,
      T0   = 3'b100,
      T1   = 3'b101,
      T2   = 3'b110,
      T3   = 3'b111
   } state_t;

   localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);
   localparam logic [WCW-1:0] WONE  = WCW'(1);

   state_t         state, state_next;
   logic [WCW-1:0] wcnt, wcnt_next;
   logic           done_next;
   logic           tmo_next;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= IDLE;
         wcnt  <= '0;
         done  <= 1'b0;
         tmo   <= 1'b0;
      end else begin
         state <= state_next;
         wcnt  <= wcnt_next;
         done  <= done_next;
         tmo   <= tmo_next;
      end
   end

   always_comb begin
      state_next = state;
      wcnt_next  = wcnt;
      done_next  = 1'b0;
      tmo_next   = tmo;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = T0;
               tmo_next   = 1'b0;
            end
         end
         T0: state_next = T1;
         T1: state_next = T2;
         T2: begin
            if (rdy) begin
               state_next = T3;
               wcnt_next  = '0;
            end else if (wcnt == WLAST) begin
               state_next = T3;
               tmo_next   = 1'b1;
               wcnt_next  = '0;
            end else begin
               wcnt_next = wcnt + WONE;
            end
         end
         T3: begin
            done_next  = 1'b1;
            state_next = rep ? T0 : IDLE;
         end
         default: begin
            state_next = IDLE;
            wcnt_next  = '0;
         end
      endcase

      // Abort overrides everything above except the sticky timeout flag.
      if (abort) begin
         state_next = IDLE;
         wcnt_next  = '0;
         done_next  = 1'b0;
         tmo_next   = tmo;
      end
   end

   assign ph    = state[1:0];
   assign ph_en = state[2];
   assign busy  = state[2];

endmodule

// File: tb/tb_am_phase_seq.sv
// Scoreboard bench for am_phase_seq: each driven cycle queues the outputs
// expected after the next edge; a monitor pops and compares every cycle.
module tb_am_phase_seq;

   logic       clk;
   logic       rst_;
   logic       start, rep, rdy, abort;
   logic [1:0] ph;
   logic       ph_en, busy, done, tmo;

   typedef struct {
      string      name;
      logic [5:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   am_phase_seq #(.TIMEOUT(8), .WCW(4)) dut (
      .clk   (clk),
      .rst_  (rst_),
      .start (start),
      .rep   (rep),
      .rdy   (rdy),
      .abort (abort),
      .ph    (ph),
      .ph_en (ph_en),
      .busy  (busy),
      .done  (done),
      .tmo   (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected vector {busy, ph_en, ph, done, tmo}; phase -1 means IDLE.
   function automatic logic [5:0] ev(int phase, bit d, bit t);
      if (phase < 0) return {4'b0000, d, t};
      return {2'b11, 2'(phase), d, t};
   endfunction

   task automatic checkOutput(string name, logic [5:0] expv);
      logic [5:0] act;
      act = {busy, ph_en, ph, done, tmo};
      checks++;
      if (act !== expv) begin
         errors++;
         $display("[TB] FAIL %s: got {busy,ph_en,ph,done,tmo}=%b expected %b at %0t",
                  name, act, expv, $time);
      end
   endtask

   task automatic applyStimulus(string name, bit s, bit r, bit y, bit a, logic [5:0] expv);
      exp_t e;
      @(negedge clk);
      start = s;
      rep   = r;
      rdy   = y;
      abort = a;
      e.name = name;
      e.v    = expv;
      exp_q.push_back(e);
   endtask

   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checkOutput(e.name, e.v);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_  = 1'b0;
      start = 1'b0;
      rep   = 1'b0;
      rdy   = 1'b0;
      abort = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset", 6'b000000);
      rst_ = 1'b1;

      applyStimulus("idle0", 0, 0, 0, 0, ev(-1, 0, 0));
      applyStimulus("idle1", 0, 0, 0, 0, ev(-1, 0, 0));

      // Zero wait states; start and rdy asserted while busy outside T2 are ignored
      applyStimulus("zw_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("zw_t1",   1, 0, 1, 0, ev(1, 0, 0));
      applyStimulus("zw_t2",   0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("zw_t3",   0, 0, 1, 0, ev(3, 0, 0));
      applyStimulus("zw_done", 0, 0, 0, 0, ev(-1, 1, 0));
      applyStimulus("zw_idle", 0, 0, 0, 0, ev(-1, 0, 0));

      // Three wait states
      applyStimulus("ws_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("ws_t1",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("ws_t2a",  0, 0, 0, 0, ev(2, 0, 0));
      for (int i = 0; i < 3; i++)
         applyStimulus("ws_t2w", 0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("ws_t3",   0, 0, 1, 0, ev(3, 0, 0));
      applyStimulus("ws_done", 0, 0, 0, 0, ev(-1, 1, 0));
      applyStimulus("ws_idle", 0, 0, 0, 0, ev(-1, 0, 0));

      // Timeout: eight T2 cycles, then T3 with sticky tmo
      applyStimulus("to_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("to_t1",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("to_t2a",  0, 0, 0, 0, ev(2, 0, 0));
      for (int i = 0; i < 7; i++)
         applyStimulus("to_t2w", 0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("to_t3",   0, 0, 0, 0, ev(3, 0, 1));
      applyStimulus("to_done", 0, 0, 0, 0, ev(-1, 1, 1));
      applyStimulus("to_idle", 0, 0, 0, 0, ev(-1, 0, 1));

      // start with abort in IDLE is rejected and leaves tmo set
      applyStimulus("sa_idle", 1, 0, 0, 1, ev(-1, 0, 1));
      applyStimulus("sa_hold", 0, 0, 0, 0, ev(-1, 0, 1));

      // Accepted start clears tmo; rep chains two cycles with two done pulses
      applyStimulus("rp_t0",    1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("rp_t1",    0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("rp_t2",    0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("rp_t3",    0, 0, 1, 0, ev(3, 0, 0));
      applyStimulus("rp_t0b",   0, 1, 0, 0, ev(0, 1, 0));
      applyStimulus("rp_t1b",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("rp_t2b",   0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("rp_t3b",   0, 0, 1, 0, ev(3, 0, 0));
      applyStimulus("rp_done",  0, 0, 0, 0, ev(-1, 1, 0));
      applyStimulus("rp_idle",  0, 0, 0, 0, ev(-1, 0, 0));

      // Abort in T2 after one wait state beats rdy; no done
      applyStimulus("ab_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("ab_t1",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("ab_t2",   0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("ab_t2w",  0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("ab_idle", 0, 0, 1, 1, ev(-1, 0, 0));
      applyStimulus("ab_nodn", 0, 0, 0, 0, ev(-1, 0, 0));

      // Abort in T3 beats rep and suppresses done
      applyStimulus("a3_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("a3_t1",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("a3_t2",   0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("a3_t3",   0, 0, 1, 0, ev(3, 0, 0));
      applyStimulus("a3_idle", 0, 1, 0, 1, ev(-1, 0, 0));
      applyStimulus("a3_nodn", 0, 0, 0, 0, ev(-1, 0, 0));

      // Timeout then rep: counter was cleared by the abort, tmo survives the repeat
      applyStimulus("tr_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("tr_t1",   0, 0, 0, 0, ev(1, 0, 0));
      applyStimulus("tr_t2a",  0, 0, 0, 0, ev(2, 0, 0));
      for (int i = 0; i < 7; i++)
         applyStimulus("tr_t2w", 0, 0, 0, 0, ev(2, 0, 0));
      applyStimulus("tr_t3",   0, 0, 0, 0, ev(3, 0, 1));
      applyStimulus("tr_t0b",  0, 1, 0, 0, ev(0, 1, 1));
      applyStimulus("tr_t1b",  0, 0, 0, 0, ev(1, 0, 1));
      applyStimulus("tr_t2b",  0, 0, 0, 0, ev(2, 0, 1));
      applyStimulus("tr_t3b",  0, 0, 1, 0, ev(3, 0, 1));
      applyStimulus("tr_done", 0, 0, 0, 0, ev(-1, 1, 1));

      // Reset asserted mid-cycle in T1 clears outputs without a clock edge
      applyStimulus("mr_t0",   1, 0, 0, 0, ev(0, 0, 0));
      applyStimulus("mr_t1",   0, 0, 0, 0, ev(1, 0, 0));
      @(negedge clk);
      rst_ = 1'b0;
      #1;
      checkOutput("mid_reset", 6'b000000);
      @(negedge clk);
      rst_ = 1'b1;
      applyStimulus("mr_idle", 0, 0, 0, 0, ev(-1, 0, 0));
      applyStimulus("mr_t0b",  1, 0, 0, 0, ev(0, 0, 0));

      for (int i = 0; i < 20 && exp_q.size() > 0; i++)
         @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         errors++;
         checks++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
